// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin sharing of one ALU16bit between two requesters; MULT runs as shift-add on the ALU's ADD.
// Build option ALU_MUL_EARLY_EXIT_EN: MUL also stops once the remaining multiplier bits are all zero.
module alu_share_ctrl #(
   parameter int DATA_W   = 16,
   parameter int OP_W     = 4,
   parameter int MUL_ITER = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [OP_W-1:0]   req0_op,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   output logic              rsp0_valid,
   output logic [DATA_W-1:0] rsp0_data,
   output logic              rsp0_zero,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [OP_W-1:0]   req1_op,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   output logic              rsp1_valid,
   output logic [DATA_W-1:0] rsp1_data,
   output logic              rsp1_zero,
   output logic [OP_W-1:0]   alu_op,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_zero,
   output logic              busy
);
   localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, MUL = 2'd2, RESP = 2'd3;
   localparam logic [OP_W-1:0] OP_MULT = OP_W'(9);
   localparam int CNT_W = $clog2(MUL_ITER + 1);
   logic [1:0]        state;
   logic [OP_W-1:0]   op;
   logic [DATA_W-1:0] opa, opb, acc;
   logic [CNT_W-1:0]  cnt;
   logic              id, last, gnt1, hs, mul_done, wr, wzero;
   logic [OP_W-1:0]   sel_op;
   // last names the requester granted most recently; the other one wins a tie
   assign gnt1       = req1_valid && (!req0_valid || !last);
   assign req1_ready = reset && state == IDLE && gnt1;
   assign req0_ready = reset && state == IDLE && req0_valid && !gnt1;
   assign hs         = req0_ready || req1_ready;
   assign sel_op     = gnt1 ? req1_op : req0_op;
`ifdef ALU_MUL_EARLY_EXIT_EN
   assign mul_done = cnt == CNT_W'(MUL_ITER - 1) || opb[DATA_W-1:1] == '0;
`else
   assign mul_done = cnt == CNT_W'(MUL_ITER - 1);
`endif
   assign alu_op     = state == EXEC ? op : '0;
   assign alu_a      = state == EXEC ? opa : state == MUL ? acc : '0;
   assign alu_b      = state == EXEC ? opb : (state == MUL && opb[0]) ? opa : '0;
   assign rsp0_valid = state == RESP && !id;
   assign rsp1_valid = state == RESP && id;
   assign busy       = state != IDLE;
   assign wr         = state == EXEC || (state == MUL && mul_done);
   assign wzero      = state == EXEC ? alu_zero : alu_result == '0;
   // in MUL, opa/opb double as the shifting multiplicand/multiplier
   always_ff @(posedge clock) begin
      if (!reset) begin
         state <= IDLE;
         last  <= 1'b1;
         id    <= 1'b0;
         op    <= '0;
         opa   <= '0;
         opb   <= '0;
         acc   <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: if (hs) begin
               state <= sel_op == OP_MULT ? MUL : EXEC;
               op    <= sel_op;
               opa   <= gnt1 ? req1_a : req0_a;
               opb   <= gnt1 ? req1_b : req0_b;
               id    <= gnt1;
               last  <= gnt1;
               acc   <= '0;
               cnt   <= '0;
            end
            EXEC: state <= RESP;
            MUL: begin
               acc   <= alu_result;
               opa   <= opa << 1;
               opb   <= opb >> 1;
               cnt   <= cnt + CNT_W'(1);
               state <= mul_done ? RESP : MUL;
            end
            RESP: state <= IDLE;
         endcase
      end
   end
   always_ff @(posedge clock) begin
      if (!reset) begin
         rsp0_data <= '0;
         rsp0_zero <= 1'b0;
         rsp1_data <= '0;
         rsp1_zero <= 1'b0;
      end else if (wr && !id) begin
         rsp0_data <= alu_result;
         rsp0_zero <= wzero;
      end else if (wr && id) begin
         rsp1_data <= alu_result;
         rsp1_zero <= wzero;
      end
   end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: randomized and directed bench for alu_share_ctrl with a behavioural ALU and transaction-level reference.
module tb_alu_share_ctrl;
   logic        clk = 0, reset = 0;
   logic        req0_valid = 0, req1_valid = 0;
   logic [3:0]  req0_op = 0, req1_op = 0;
   logic [15:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
   logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_zero, rsp1_zero, busy, alu_zero;
   logic [15:0] rsp0_data, rsp1_data, alu_a, alu_b, alu_result;
   logic [3:0]  alu_op;
   int n_cmp = 0, n_err = 0, cyc = 0;

   alu_share_ctrl dut (
      .clock(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
      .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_zero(rsp0_zero),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
      .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_zero(rsp1_zero),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result), .alu_zero(alu_zero),
      .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic logic [15:0] alu_f(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      logic [31:0] p;
      p = 32'(a) * 32'(b);
      case (op)
         4'b0000: return a + b;
         4'b0001: return a - b;
         4'b0010: return a & b;
         4'b0011: return a | b;
         4'b1001: return p[15:0];
         4'b1110: return {15'd0, a == 16'd0};
         default: return a ^ b;
      endcase
   endfunction
   assign alu_result = alu_f(alu_op, alu_a, alu_b);
   assign alu_zero   = alu_result == 16'd0;

   function automatic int mul_iters(input logic [15:0] b);
`ifdef ALU_MUL_EARLY_EXIT_EN
      int n = 1;
      for (int i = 1; i < 16; i++) if (b[i]) n = i + 1;
      return n;
`else
      return 16;
`endif
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, obs, exp);
      end
   endtask

   // reference state: one outstanding transaction, tracked by cycle numbers
   bit          last_m, idle_m, er0, er1, hk, dn;
   bit          pend [2];
   int          due [2];
   logic [15:0] exp_d [2], held_d [2];
   bit          exp_z [2], held_z [2];
   int          busy_until, exec_cyc, mul_first, mul_last;
   logic [3:0]  ex_op, h_op;
   logic [15:0] ex_a, ex_b, h_a, h_b, r;

   always @(negedge clk) begin
      if (!reset) begin
         pend[0] = 0; pend[1] = 0; held_d[0] = 0; held_d[1] = 0; held_z[0] = 0; held_z[1] = 0;
         last_m = 1; busy_until = cyc; exec_cyc = -1; mul_first = -1; mul_last = -1;
      end else begin
         idle_m = cyc > busy_until;
         er1 = idle_m && req1_valid && (!req0_valid || !last_m);
         er0 = idle_m && req0_valid && !er1;
         check("busy", busy, !idle_m);
         check("req0_ready", req0_ready, er0);
         check("req1_ready", req1_ready, er1);
         if (idle_m) check("alu_idle", {alu_op, alu_a, alu_b}, 36'd0);
         if (cyc == exec_cyc) check("alu_exec", {alu_op, alu_a, alu_b}, {ex_op, ex_a, ex_b});
         if (cyc >= mul_first && cyc <= mul_last) check("alu_mul_op", alu_op, 4'b0000);
         if (cyc == mul_first) check("alu_mul_first", {alu_a, alu_b}, {16'd0, ex_b[0] ? ex_a : 16'd0});
         for (int k = 0; k < 2; k++) begin
            dn = pend[k] && cyc == due[k];
            check(k ? "rsp1_valid" : "rsp0_valid", k ? rsp1_valid : rsp0_valid, dn);
            if (dn) begin
               held_d[k] = exp_d[k];
               held_z[k] = exp_z[k];
               pend[k] = 0;
            end
            check(k ? "rsp1_data" : "rsp0_data", k ? rsp1_data : rsp0_data, held_d[k]);
            check(k ? "rsp1_zero" : "rsp0_zero", k ? rsp1_zero : rsp0_zero, held_z[k]);
         end
         if (er0 || er1) begin
            hk   = er1;
            h_op = hk ? req1_op : req0_op;
            h_a  = hk ? req1_a : req0_a;
            h_b  = hk ? req1_b : req0_b;
            r    = alu_f(h_op, h_a, h_b);
            last_m = hk;
            pend[hk] = 1;
            exp_d[hk] = r;
            exp_z[hk] = r == 16'd0;
            ex_op = h_op; ex_a = h_a; ex_b = h_b;
            if (h_op == 4'b1001) begin
               due[hk] = cyc + 1 + mul_iters(h_b);
               mul_first = cyc + 1;
               mul_last = cyc + mul_iters(h_b);
            end else begin
               due[hk] = cyc + 2;
               exec_cyc = cyc + 1;
            end
            busy_until = due[hk];
         end
      end
   end

   task automatic issue(input bit id, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      int t = 0;
      @(posedge clk); #1;
      if (id) begin req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; end
      else begin req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; end
      do begin @(negedge clk); t++; end while (!(id ? req1_ready : req0_ready) && t < 200);
      check("grant_timeout", t < 200, 1);
      @(posedge clk); #1;
      if (id) begin req1_valid = 0; req1_op = 4'($urandom); req1_a = 16'($urandom); req1_b = 16'($urandom); end
      else begin req0_valid = 0; req0_op = 4'($urandom); req0_a = 16'($urandom); req0_b = 16'($urandom); end
   endtask

   task automatic wait_idle();
      int t = 0;
      while ((busy || pend[0] || pend[1]) && t < 100) begin @(negedge clk); #1; t++; end
      check("idle_timeout", t < 100, 1);
   endtask

   task automatic do_reset(input int n);
      @(posedge clk); #1 reset = 0;
      repeat (n) @(posedge clk);
      #1 reset = 1;
   endtask

   logic [3:0] ops [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd9, 4'd14, 4'd11};

   initial begin
      repeat (2) @(posedge clk);
      #1 reset = 1;
      @(negedge clk);
      check("reset_busy", busy, 0);
      check("reset_rsp0_data", rsp0_data, 16'd0);
      issue(0, 4'b0000, 16'd13, 16'd24);
      wait_idle();
      check("add_data", rsp0_data, 16'd37);
      check("add_zero", rsp0_zero, 0);
      check("add_rsp1_untouched", rsp1_data, 16'd0);
      do_reset(1);
      fork
         issue(0, 4'b0001, 16'd5, 16'd5);
         issue(1, 4'b0001, 16'd0, 16'd15);
      join
      wait_idle();
      check("sub0_data", rsp0_data, 16'h0000);
      check("sub0_zero", rsp0_zero, 1);
      check("sub1_data", rsp1_data, 16'hFFF1);
      check("sub1_zero", rsp1_zero, 0);
      fork
         for (int i = 0; i < 3; i++) issue(0, 4'b0011, 16'(i), 16'h0100);
         for (int i = 0; i < 3; i++) issue(1, 4'b0000, 16'(i), 16'h0200);
      join
      wait_idle();
      issue(1, 4'b1001, 16'd3, 16'h0011);
      wait_idle();
      check("mul_data", rsp1_data, 16'h0033);
      issue(0, 4'b1001, 16'h0100, 16'h0100);
      wait_idle();
      check("mul_ovf_data", rsp0_data, 16'h0000);
      check("mul_ovf_zero", rsp0_zero, 1);
      issue(1, 4'b1001, 16'h1234, 16'h0000);
      wait_idle();
      check("mul_b0_data", rsp1_data, 16'h0000);
      issue(0, 4'b1001, 16'h0003, 16'h0005);
      repeat (3) @(posedge clk);
      #1 reset = 0;
      @(posedge clk); #1 reset = 1;
      @(negedge clk);
      check("abort_busy", busy, 0);
      fork
         issue(0, 4'b0011, 16'h00F0, 16'h0F00);
         issue(1, 4'b0000, 16'h0001, 16'h0001);
      join
      wait_idle();
      check("or_data", rsp0_data, 16'h0FF0);
      issue(0, 4'b1110, 16'h0000, 16'h0005);
      wait_idle();
      check("eq0_data", rsp0_data, 16'h0001);
      check("eq0_zero", rsp0_zero, 0);
      fork
         for (int i = 0; i < 15; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            issue(0, ops[$urandom_range(0, 7)], 16'($urandom), $urandom_range(0, 2) == 0 ? 16'($urandom_range(0, 255)) : 16'($urandom));
         end
         for (int i = 0; i < 15; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            issue(1, ops[$urandom_range(0, 7)], 16'($urandom), $urandom_range(0, 2) == 0 ? 16'($urandom_range(0, 255)) : 16'($urandom));
         end
      join
      wait_idle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
Controller that shares the single ALU16bit instance between two requesters (req0: main datapath, req1: address/branch unit).
- Arbitrates round-robin and registers the winner's operands.
- Drives the ALU and returns a registered result with a one-cycle response pulse.
- Executes MULT (aluOp 1001) as a multi-cycle shift-add sequence that reuses the shared ALU's ADD, so the ALU itself never performs MULT.

Parameters:
DATA_W, 16, operand/result width (must match ALU16bit)
OP_W, 4, aluOp width
MUL_ITER, 16, shift-add iterations for MULT (must equal DATA_W)

Ports:
clock  in  1  single system clock, rising edge
reset  in  1  synchronous, active-low reset
req0_valid  in  1  requester 0 has an operation pending
req0_ready  out  1  requester 0 operation accepted this cycle
req0_op  in  OP_W  aluOp encoding
req0_a  in  DATA_W  operand A
req0_b  in  DATA_W  operand B
rsp0_valid  out  1  one-cycle result pulse to requester 0
rsp0_data  out  DATA_W  result
rsp0_zero  out  1  result-is-zero flag
req1_valid / req1_ready / req1_op / req1_a / req1_b  same as req0, for requester 1
rsp1_valid / rsp1_data / rsp1_zero  same as rsp0, for requester 1
alu_op  out  OP_W  to ALU16bit aluOp
alu_a  out  DATA_W  to ALU16bit aIn
alu_b  out  DATA_W  to ALU16bit bIn
alu_result  in  DATA_W  from ALU16bit outPut
alu_zero  in  1  from ALU16bit isZero
busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (reset==0 at a clock edge):
  - FSM goes to IDLE; all rsp*_valid, req*_ready and busy go to 0; rsp*_data go to 0; rsp*_zero go to 0.
  - The round-robin pointer is set so req0 has priority.
  - Reset mid-operation abandons the operation: no response is issued for it.
- ALU outputs are combinational from state. In IDLE they are alu_op=0000, alu_a=0, alu_b=0.
- FSM states: IDLE, EXEC, MUL, RESP.
- IDLE:
  - If only one requester is valid, it is granted. If both are valid, the requester not granted last is granted.
  - reqN_ready is combinational: asserted only in IDLE, only for the granted requester. The handshake completes on valid&&ready.
  - On handshake, latch op, a, b, requester id, and update the pointer.
  - op==1001 goes to MUL; any other op goes to EXEC.
  - Opcodes 1010–1101 are passed to the ALU unchanged and are not decoded.
- EXEC: drive alu_op/alu_a/alu_b from the latched values. Capture alu_result and alu_zero at the cycle end, then go to RESP.
- MUL:
  - On entry: acc=0, mcand=a, mplier=b, cnt=0.
  - Each cycle drives alu_op=0000 (ADD), alu_a=acc, alu_b=(mplier[0] ? mcand : 0).
  - At cycle end: acc<=alu_result, mcand<=mcand<<1, mplier<=mplier>>1, cnt<=cnt+1.
  - Exit to RESP after MUL_ITER cycles (subject to the optional feature).
  - Result is the low DATA_W bits (overflow discarded). Zero flag = (result==0), computed locally.
- RESP:
  - Assert rspN_valid for exactly one cycle on the latched id. rspN_data/rspN_zero are valid with it and hold until the next response to that requester.
  - The other requester's rsp_valid stays 0. No backpressure.
  - Return to IDLE; a new grant is possible in the following cycle.
- Latency, with handshake at cycle T:
  - Single-cycle ops: EXEC at T+1, rsp_valid at T+2.
  - MULT: rsp_valid at T+1+iterations.
  - Throughput: one operation per 3 cycles minimum.
- A requester dropping valid before ready is legal; it is simply not granted.
- Inputs are not sampled outside the handshake cycle.

Optional Feature:
ALU_MUL_EARLY_EXIT_EN
- Defined: MUL also exits when the post-shift mplier==0. MUL always executes at least one iteration (b==0 still takes 1 cycle).
- Undefined: MUL always takes exactly MUL_ITER cycles.
- Result values are identical in both builds; only latency differs.

Test Plan:
- Reset low 2 cycles, then req0 ADD a=13,b=24 → req0_ready at T, rsp0_valid at T+2, rsp0_data=37, rsp0_zero=0; rsp1_valid stays 0.
- req0 and req1 both held valid with SUB 5-5 and SUB 0-15 → req0 granted first: rsp0_data=0x0000, zero=1. Then req1 granted: rsp1_data=0xFFF1, zero=0. Grants alternate while both stay valid.
- req1 MULT a=3,b=0x0011 → rsp1_data=0x0033. rsp at T+17 without the macro; rsp at T+6 with ALU_MUL_EARLY_EXIT_EN (5 iterations).
- MULT a=0x0100,b=0x0100 → rsp_data=0x0000, rsp_zero=1 (overflow discarded). MULT b=0 with macro → rsp at T+2, data 0.
- Reset asserted at T+5 of a MULT → no rsp_valid, busy=0 after the edge. Next req0 OR 0x00F0|0x0F00 → 0x0FF0 with normal latency; req0 has priority.
- Op 1110 (EQ0) a=0 → alu_op=1110 during EXEC, rsp_data equals the ALU output (1), rsp_zero = alu_zero sampled in EXEC.
